alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the team's combinational 4-bit ALU: same 3-bit opcode space, generic WIDTH, valid/ready handshake on both sides, carry/zero flags.
- Multiply is an iterative shift-add unit; all other ops complete in one cycle.
- Sits between the operand source (sequencer/testbench driver) and the result consumer; the 4-bit instance (WIDTH=4) remains exhaustively sweepable over {oc,a,b} = 2048 vectors.

Parameters:
- WIDTH, 4, operand/result width in bits (≥2).
- SW, $clog2(WIDTH), width of the shift-amount field taken from b for SHL range checks (derived).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands/opcode valid.
- in_ready  output  1  block can accept; a transfer occurs on an edge with in_valid && in_ready.
- oc  input  3  opcode.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- out_valid  output  1  result valid; held until taken.
- out_ready  input  1  consumer takes the result on an edge with out_valid && out_ready.
- out  output  WIDTH  result.
- carry  output  1  carry/borrow/overflow flag per opcode.
- zero  output  1  1 iff out == 0.

Behaviour:
- Opcodes:
  - 000 ADD: out = a+b mod 2^WIDTH; carry = carry-out.
  - 001 SUB: out = a-b mod 2^WIDTH; carry = borrow (a<b).
  - 010 AND; 011 OR; 100 XOR; 101 NOT a. For all four, carry=0.
  - 110 SHL: out = a<<b. If b≥WIDTH, out=0. carry = last bit shifted out (bit WIDTH-b of a) for 1≤b≤WIDTH, else 0.
  - 111 MUL: out = low WIDTH bits of a*b; carry = 1 iff the high WIDTH bits are non-zero.
- FSM states: IDLE, EXEC, DONE. Reset state is IDLE.
  - IDLE: in_ready=1. On accept, capture oc/a/b. Single-cycle op: compute and go to DONE. MUL: clear the 2*WIDTH accumulator, load the multiplier/multiplicand shift registers, set the iteration counter to WIDTH, go to EXEC.
  - EXEC: in_ready=0. Each cycle: add the multiplicand to the accumulator if multiplier LSB=1, shift, decrement the counter. When the counter reaches 0, go to DONE with the result registered.
  - DONE: out_valid=1. out, carry and zero are stable while out_ready=0.
    - out_ready=1, in_valid=0: go to IDLE.
    - out_ready=1, in_valid=1: accept the new op in the same edge and go to DONE (single-cycle) or EXEC (MUL). in_ready = out_ready in DONE (combinational).
- Latency from accept edge to out_valid high:
  - 1 cycle for single-cycle ops.
  - WIDTH+1 cycles for MUL.
  - Throughput: one single-cycle op per clock under continuous out_ready.
- Operand inputs are sampled only on accept; later changes on a/b/oc have no effect on an op in flight.
- Reset values (asynchronous, immediate on rst=1): state=IDLE, out_valid=0, out=0, carry=0, zero=0, counter=0, accumulator=0. in_ready becomes 1 after reset release.
- Reset mid-EXEC or mid-DONE aborts the operation; no result is ever emitted for it.
- zero is computed from the registered out, never from the accumulator's high half.
- An unknown/X oc is not defined; the bench drives only legal 3-bit values.

Test Plan:
- Exhaustive sweep, WIDTH=4: for j=0..2047 drive {oc,a,b}=j with out_ready=1. Every result matches the reference model, including carry/zero.
  - Spot checks: ADD 9+8 -> out=1, carry=1. SUB 3-5 -> out=14, carry=1.
- MUL timing, WIDTH=4: accept a=7, b=3 at edge T. out_valid stays 0 through T+4 and rises at T+5, with out=5, carry=1 (21=0x15).
  - in_ready stays 0 during EXEC.
  - 0*15 -> out=0, zero=1, carry=0.
- SHL boundaries, WIDTH=4: a=0b1011, b=1 -> out=0b0110, carry=1. b=4 -> out=0, carry=1. b=5 -> out=0, carry=0, zero=1.
- Backpressure: hold out_ready=0 for 10 cycles after ADD 2+2. out=4 and out_valid stay stable and in_ready=0; release -> a single transfer.
- Back-to-back: in DONE with out_ready=1 and in_valid=1 (XOR 0xA,0x5), the next edge shows the new result 0xF with no IDLE bubble.
- Reset mid-op: assert rst during EXEC of MUL 15*15. out_valid=0 immediately, state IDLE; after release, ADD 1+1 -> out=2 with 1-cycle latency.

Source files
------------

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake; single-cycle ops take 1 cycle, MUL is shift-add taking WIDTH+1 cycles.
// Result is held in DONE until taken; in_ready follows out_ready there so a new op can chain with no bubble.
module alu_seq #(
    parameter int WIDTH = 4,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       oc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LP_CNT = CW'(WIDTH);
    localparam logic [SW:0]   LP_WS  = (SW + 1)'(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
    typedef enum logic [2:0] {
        OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
        OP_XOR = 3'b100, OP_NOT = 3'b101, OP_SHL = 3'b110, OP_MUL = 3'b111
    } op_t;

    state_t r_state, w_state_n;

    logic [WIDTH-1:0]   r_out;
    logic               r_carry;
    logic               r_zero;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;

    logic               w_accept;
    logic               w_is_mul;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH:0]     w_shl_wide;
    logic               w_shl_big;
    logic [WIDTH-1:0]   w_alu_out;
    logic               w_alu_carry;
    logic [2*WIDTH-1:0] w_acc_add;

    assign w_accept = in_valid && in_ready;
    assign w_is_mul = (oc == OP_MUL);

    assign w_sum      = {1'b0, a} + {1'b0, b};
    assign w_diff     = {1'b0, a} - {1'b0, b};
    assign w_shl_wide = {1'b0, a} << b;
    // b >= WIDTH: any bit above the shift field, or a field value past WIDTH when WIDTH is not a power of two
    assign w_shl_big  = (|(b >> SW)) || ({1'b0, b[SW-1:0]} >= LP_WS);

    always_comb begin
        w_alu_out   = '0;
        w_alu_carry = 1'b0;
        case (oc)
            OP_ADD: begin
                w_alu_out   = w_sum[WIDTH-1:0];
                w_alu_carry = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_alu_out   = w_diff[WIDTH-1:0];
                w_alu_carry = w_diff[WIDTH];
            end
            OP_AND: w_alu_out = a & b;
            OP_OR:  w_alu_out = a | b;
            OP_XOR: w_alu_out = a ^ b;
            OP_NOT: w_alu_out = ~a;
            OP_SHL: begin
                w_alu_out   = w_shl_big ? '0 : w_shl_wide[WIDTH-1:0];
                w_alu_carry = w_shl_wide[WIDTH];
            end
            default: begin
                w_alu_out   = '0;
                w_alu_carry = 1'b0;
            end
        endcase
    end

    assign w_acc_add = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = !rst;
                if (w_accept) begin
                    w_state_n = w_is_mul ? S_EXEC : S_DONE;
                end
            end
            S_EXEC: begin
                if (r_cnt == '0) begin
                    w_state_n = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready && !rst;
                if (out_ready) begin
                    if (w_accept) begin
                        w_state_n = w_is_mul ? S_EXEC : S_DONE;
                    end else begin
                        w_state_n = S_IDLE;
                    end
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out    <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            if (w_is_mul) begin
                r_acc    <= '0;
                r_mcand  <= {{WIDTH{1'b0}}, a};
                r_mplier <= b;
                r_cnt    <= LP_CNT;
            end else begin
                r_out   <= w_alu_out;
                r_carry <= w_alu_carry;
                r_zero  <= (w_alu_out == '0);
            end
        end else if (r_state == S_EXEC) begin
            if (r_cnt != '0) begin
                r_acc    <= w_acc_add;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt - CW'(1);
            end else begin
                // zero looks only at the low half; a non-zero high half is reported through carry
                r_out   <= r_acc[WIDTH-1:0];
                r_carry <= |r_acc[2*WIDTH-1:WIDTH];
                r_zero  <= (r_acc[WIDTH-1:0] == '0);
            end
        end
    end

    assign out   = r_out;
    assign carry = r_carry;
    assign zero  = r_zero;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=4): scoreboard for every result, plus per-scenario inline checks.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] oc;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out;
    logic       carry;
    logic       zero;

    int total = 0;
    int bad   = 0;
    logic [5:0] sb[$];

    alu_seq #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .oc(oc), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .carry(carry), .zero(zero)
    );

    always #5 clk = ~clk;

    // Reference: returns {carry, zero, out}
    function automatic logic [5:0] model(input logic [2:0] op, input logic [3:0] x, input logic [3:0] y);
        int p;
        int idx;
        logic [3:0] o;
        logic c;
        o = 4'd0;
        c = 1'b0;
        case (op)
            3'd0: begin p = x + y; o = 4'(p % 16); c = (p > 15); end
            3'd1: begin p = x - y + 16; o = 4'(p % 16); c = (x < y); end
            3'd2: o = x & y;
            3'd3: o = x | y;
            3'd4: o = x ^ y;
            3'd5: o = ~x;
            3'd6: begin
                p = x * (1 << y);
                o = (y >= 4) ? 4'd0 : 4'(p % 16);
                if (y >= 1 && y <= 4) begin
                    idx = 4 - y;
                    c = x[idx];
                end
            end
            default: begin p = x * y; o = 4'(p % 16); c = (p >= 16); end
        endcase
        return {c, (o == 4'd0), o};
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            total = total + 1;
            if (sb.size() == 0) begin
                bad = bad + 1;
                $display("FAIL sb_unexpected got out=%h c=%b z=%b with nothing expected", out, carry, zero);
            end else begin
                logic [5:0] e;
                e = sb.pop_front();
                if ({carry, zero, out} !== e) begin
                    bad = bad + 1;
                    $display("FAIL sb_result got c=%b z=%b out=%h need c=%b z=%b out=%h",
                             carry, zero, out, e[5], e[4], e[3:0]);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [3:0] x, input logic [3:0] y);
        int n;
        n = 0;
        oc = op; a = x; b = y;
        in_valid = 1'b1;
        sb.push_back(model(op, x, y));
        while (in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            total = total + 1;
            bad = bad + 1;
            $display("FAIL send_timeout in_ready=%b need 1", in_ready);
            void'(sb.pop_back());
            in_valid = 1'b0;
        end else begin
            tick();
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_out;
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            total = total + 1;
            bad = bad + 1;
            $display("FAIL wait_out_timeout out_valid=%b need 1", out_valid);
        end
    endtask

    task automatic drain;
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        total = total + 1;
        if (sb.size() != 0) begin
            bad = bad + 1;
            $display("FAIL drain pending=%0d need 0", sb.size());
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        oc = 3'd0; a = 4'd0; b = 4'd0;
        #2;
        total = total + 1;
        if ({out_valid, out, carry, zero, in_ready} !== 8'b0) begin
            bad = bad + 1;
            $display("FAIL reset_vals got ov=%b out=%h c=%b z=%b ir=%b need all 0",
                     out_valid, out, carry, zero, in_ready);
        end
        tick();
        tick();
        rst = 1'b0;
        #1;
        total = total + 1;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL reset_release got ir=%b ov=%b need ir=1 ov=0", in_ready, out_valid);
        end
    endtask

    task automatic test_spot;
        out_ready = 1'b1;
        send(3'd0, 4'd9, 4'd8);
        total = total + 1;
        if (out_valid !== 1'b1 || out !== 4'd1 || carry !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL add_9_8 got ov=%b out=%0d c=%b need ov=1 out=1 c=1", out_valid, out, carry);
        end
        send(3'd1, 4'd3, 4'd5);
        total = total + 1;
        if (out_valid !== 1'b1 || out !== 4'd14 || carry !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL sub_3_5 got ov=%b out=%0d c=%b need ov=1 out=14 c=1", out_valid, out, carry);
        end
        drain();
    endtask

    task automatic test_sweep;
        logic [10:0] v;
        out_ready = 1'b1;
        for (int j = 0; j < 2048; j++) begin
            v = j[10:0];
            send(v[10:8], v[7:4], v[3:0]);
        end
        drain();
    endtask

    task automatic test_mul_timing;
        out_ready = 1'b1;
        oc = 3'd7; a = 4'd7; b = 4'd3;
        in_valid = 1'b1;
        sb.push_back(model(3'd7, 4'd7, 4'd3));
        tick();
        in_valid = 1'b0;
        oc = 3'd0; a = 4'hF; b = 4'hF;
        for (int k = 0; k < 5; k++) begin
            total = total + 1;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                bad = bad + 1;
                $display("FAIL mul_exec_T+%0d got ov=%b ir=%b need ov=0 ir=0", k, out_valid, in_ready);
            end
            if (k < 4) tick();
        end
        tick();
        total = total + 1;
        if (out_valid !== 1'b1 || out !== 4'd5 || carry !== 1'b1 || zero !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL mul_7_3 at T+5 got ov=%b out=%0d c=%b z=%b need ov=1 out=5 c=1 z=0",
                     out_valid, out, carry, zero);
        end
        drain();
        send(3'd7, 4'd0, 4'd15);
        wait_out();
        total = total + 1;
        if (out !== 4'd0 || zero !== 1'b1 || carry !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL mul_0_15 got out=%0d c=%b z=%b need out=0 c=0 z=1", out, carry, zero);
        end
        drain();
    endtask

    task automatic test_shl;
        logic [3:0] bv [3];
        logic [5:0] need [3];
        bv[0] = 4'd1; need[0] = {1'b1, 1'b0, 4'b0110};
        bv[1] = 4'd4; need[1] = {1'b1, 1'b1, 4'b0000};
        bv[2] = 4'd5; need[2] = {1'b0, 1'b1, 4'b0000};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(3'd6, 4'b1011, bv[i]);
            total = total + 1;
            if (out_valid !== 1'b1 || {carry, zero, out} !== need[i]) begin
                bad = bad + 1;
                $display("FAIL shl_b%0d got ov=%b c=%b z=%b out=%b need ov=1 c=%b z=%b out=%b",
                         bv[i], out_valid, carry, zero, out, need[i][5], need[i][4], need[i][3:0]);
            end
        end
        drain();
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        send(3'd0, 4'd2, 4'd2);
        for (int k = 0; k < 10; k++) begin
            a = 4'(k); b = 4'(k + 3);
            total = total + 1;
            if (out_valid !== 1'b1 || out !== 4'd4 || in_ready !== 1'b0) begin
                bad = bad + 1;
                $display("FAIL hold_cyc%0d got ov=%b out=%0d ir=%b need ov=1 out=4 ir=0",
                         k, out_valid, out, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        total = total + 1;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            bad = bad + 1;
            $display("FAIL hold_release got ov=%b pending=%0d need ov=0 pending=0", out_valid, sb.size());
        end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        send(3'd0, 4'd1, 4'd2);
        oc = 3'd4; a = 4'hA; b = 4'h5;
        in_valid = 1'b1;
        sb.push_back(model(3'd4, 4'hA, 4'h5));
        total = total + 1;
        if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL b2b_ready got ov=%b ir=%b need ov=1 ir=1", out_valid, in_ready);
        end
        tick();
        in_valid = 1'b0;
        total = total + 1;
        if (out_valid !== 1'b1 || out !== 4'hF || carry !== 1'b0 || zero !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL b2b_xor got ov=%b out=%h c=%b z=%b need ov=1 out=f c=0 z=0",
                     out_valid, out, carry, zero);
        end
        drain();
    endtask

    task automatic test_reset_mid_op;
        out_ready = 1'b1;
        oc = 3'd7; a = 4'd15; b = 4'd15;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        total = total + 1;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL rst_mid_exec got ov=%b ir=%b need ov=0 ir=0", out_valid, in_ready);
        end
        tick();
        rst = 1'b0;
        #1;
        total = total + 1;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL rst_idle got ov=%b ir=%b need ov=0 ir=1", out_valid, in_ready);
        end
        send(3'd0, 4'd1, 4'd1);
        total = total + 1;
        if (out_valid !== 1'b1 || out !== 4'd2) begin
            bad = bad + 1;
            $display("FAIL rst_then_add got ov=%b out=%0d need ov=1 out=2", out_valid, out);
        end
        drain();
        for (int k = 0; k < 8; k++) tick();
        total = total + 1;
        if (out_valid !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL rst_no_stray got ov=%b need 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_spot();
        test_mul_timing();
        test_shl();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
